// File: rtl/tlk2711_link_ctrl.sv
// TLK2711 transmit-path link sequencer: power-up / lock-reference timing,
// start/stop handshake with the serdes, and static pin control.
module tlk2711_link_ctrl #(
  parameter int unsigned PWRUP_CYCLES = 8000,
  parameter int unsigned LOCK_CYCLES  = 4000,
  parameter int unsigned STOP_TIMEOUT = 1024,
  parameter int unsigned RESTART_GAP  = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_mode,
  input  logic       err_clr,
  output logic       o_start,
  output logic [1:0] o_mode,
  output logic       o_stop,
  input  logic       i_stop_ack,
  output logic       o_enable,
  output logic       o_lckrefn,
  output logic       o_loopen,
  output logic       o_prbsen,
  output logic       o_testen,
  output logic       link_ready,
  output logic       running,
  output logic       err_timeout,
  output logic       err_illegal,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PWRUP = 3'd1,
    S_LOCK  = 3'd2,
    S_IDLE  = 3'd3,
    S_START = 3'd4,
    S_RUN   = 3'd5,
    S_STOP  = 3'd6,
    S_GAP   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_PDOWN = 2'd2,
    OP_PUP   = 2'd3
  } op_t;

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((RESTART_GAP == 0) ? 0 : RESTART_GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boot_q;
  logic [1:0]       mode_d;
  logic             accept, ill_set, to_set;

  always_comb begin
    state_d = state_q;
    mode_d  = o_mode;
    ill_set = 1'b0;
    to_set  = 1'b0;
    accept  = cmd_valid & cmd_ready;
    case (state_q)
      S_OFF: begin
        // boot_q gives the automatic power-up after reset; a later POWER_DOWN parks here
        if (boot_q) state_d = S_PWRUP;
        if (accept) begin
          if (op_t'(cmd_op) == OP_PUP) state_d = S_PWRUP;
          else                         ill_set = 1'b1;
        end
      end
      S_PWRUP: if (cnt_q == PWRUP_LAST) state_d = S_LOCK;
      S_LOCK:  if (cnt_q == LOCK_LAST)  state_d = S_IDLE;
      S_IDLE: begin
        if (accept) begin
          case (op_t'(cmd_op))
            OP_START: begin
              state_d = S_START;
              mode_d  = cmd_mode;
            end
            OP_PDOWN: state_d = S_OFF;
            default:  ill_set = 1'b1;
          endcase
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (accept) begin
          if (op_t'(cmd_op) == OP_STOP) state_d = S_STOP;
          else                           ill_set = 1'b1;
        end
      end
      S_STOP: begin
        if (i_stop_ack) begin
          state_d = S_GAP;
        end else if (cnt_q == STOP_LAST) begin
          state_d = S_GAP;
          to_set  = 1'b1;
        end
      end
      S_GAP:   if (cnt_q == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_OFF;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Outputs are registered from the next state so they change together with state_q.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      boot_q      <= 1'b1;
      o_mode      <= '0;
      cmd_ready   <= 1'b0;
      o_start     <= 1'b0;
      o_stop      <= 1'b0;
      o_enable    <= 1'b0;
      o_lckrefn   <= 1'b0;
      o_loopen    <= 1'b0;
      o_prbsen    <= 1'b0;
      link_ready  <= 1'b0;
      running     <= 1'b0;
      err_timeout <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      boot_q      <= boot_q & (state_d == S_OFF);
      o_mode      <= mode_d;
      cmd_ready   <= state_d inside {S_OFF, S_IDLE, S_RUN};
      o_start     <= state_d == S_START;
      o_stop      <= state_d == S_STOP;
      o_enable    <= state_d != S_OFF;
      o_lckrefn   <= !(state_d inside {S_OFF, S_PWRUP});
      o_loopen    <= (state_d == S_RUN) && (mode_d == 2'b10);
      o_prbsen    <= (state_d == S_RUN) && (mode_d == 2'b11);
      link_ready  <= state_d inside {S_IDLE, S_START, S_RUN, S_STOP, S_GAP};
      running     <= state_d == S_RUN;
      err_timeout <= to_set  | (err_timeout & ~err_clr);
      err_illegal <= ill_set | (err_illegal & ~err_clr);
    end
  end

  assign o_testen = 1'b0;
  assign state_o  = state_q;

endmodule
